// File: rtl/hs32_opfetch_pkg.sv
// Shared CPU constants used by the operand-fetch stage.
// Holds the default register-file geometry and the fetch FSM encoding.
// Decode-owned control fields are deliberately absent; the fetch stage
// carries them as an opaque tag.
package hs32_opfetch_pkg;

    // Register file geometry: 16 registers of 32 bits.
    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 32;
    localparam int CTL_W_DEF  = 16;

    // Operand-fetch sequencer states.
    // IDLE : nothing in flight, ready for a request
    // READ : register file read data is arriving, operands are captured
    // HOLD : operands are presented to execute until consumed
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_HOLD = 2'd2
    } opf_state_t;

endpackage : hs32_opfetch_pkg

// File: rtl/hs32_opfetch.sv
// HS32 operand fetch stage.
// Accepts an operand request from decode, drives the external register file
// read ports, captures both operands one cycle later with same-cycle
// writeback forwarding, and holds them for execute until they are consumed.
// Writeback traffic is passed straight to the register file write port and
// always wins over new requests.
module hs32_opfetch
    import hs32_opfetch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTL_W  = CTL_W_DEF
) (
    input  logic              clk,
    input  logic              reset,

    // Request from decode
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_rs1,
    input  logic [ADDR_W-1:0] req_rs2,
    input  logic [ADDR_W-1:0] req_rd,
    input  logic [DATA_W-1:0] req_imm,
    input  logic [CTL_W-1:0]  req_ctl,

    // Writeback from the end of the pipe
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_adr,
    input  logic [DATA_W-1:0] wb_data,

    // External register file
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_wadr,
    output logic [DATA_W-1:0] rf_din,
    output logic [ADDR_W-1:0] rf_radr1,
    output logic [ADDR_W-1:0] rf_radr2,
    input  logic [DATA_W-1:0] rf_dout1,
    input  logic [DATA_W-1:0] rf_dout2,

    // Operands to execute
    output logic              op_valid,
    input  logic              op_ready,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic [ADDR_W-1:0] op_rd,
    output logic [DATA_W-1:0] op_imm,
    output logic [CTL_W-1:0]  op_ctl
);

    opf_state_t state, state_nxt;

    // Request fields latched at the handshake
    logic [ADDR_W-1:0] rs1_q;
    logic [ADDR_W-1:0] rs2_q;
    logic [ADDR_W-1:0] rd_q;
    logic [DATA_W-1:0] imm_q;
    logic [CTL_W-1:0]  ctl_q;

    logic handshake;
    logic fwd_a;
    logic fwd_b;
    logic load_ops;
    logic release_ops;

    // Writeback goes straight to the register file write port; it is never
    // stalled and is masked only while reset is asserted.
    always_comb begin
        rf_we   = wb_valid & ~reset;
        rf_wadr = wb_adr;
        rf_din  = wb_data;
    end

    // Request acceptance: only when the write port is quiet and either
    // nothing is in flight or the held operands are being consumed now.
    always_comb begin
        req_ready = 1'b0;
        if (!reset && !wb_valid) begin
            req_ready = (state == ST_IDLE) ||
                        ((state == ST_HOLD) && op_ready);
        end
        handshake = req_valid & req_ready;
    end

    // Read addresses follow decode while a request can be taken, so the
    // registered read data is ready in READ; otherwise they stay on the
    // latched sources.
    always_comb begin
        rf_radr1 = rs1_q;
        rf_radr2 = rs2_q;
        if (req_ready) begin
            rf_radr1 = req_rs1;
            rf_radr2 = req_rs2;
        end
    end

    // Forwarding selects: a write landing on a source register in the
    // capture cycle is not visible on the frozen read data, so take it
    // from the write port instead.
    always_comb begin
        fwd_a = rf_we && (rf_wadr == rs1_q);
        fwd_b = rf_we && (rf_wadr == rs2_q);
    end

    // Next-state logic for the fetch sequencer.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        state_nxt   = state;
        load_ops    = 1'b0;
        release_ops = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (handshake) begin
                    state_nxt = ST_READ;
                end
            end
            ST_READ: begin
                // Exactly one cycle, whatever the writeback port is doing.
                load_ops  = 1'b1;
                state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (op_ready) begin
                    release_ops = 1'b1;
                    state_nxt   = handshake ? ST_READ : ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register; reset wins over any same-cycle handshake.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every register samples pre-edge values regardless of block order.
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Latch the request fields at the handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            rs1_q <= '0;
            rs2_q <= '0;
            rd_q  <= '0;
            imm_q <= '0;
            ctl_q <= '0;
        end else if (handshake) begin
            rs1_q <= req_rs1;
            rs2_q <= req_rs2;
            rd_q  <= req_rd;
            imm_q <= req_imm;
            ctl_q <= req_ctl;
        end
    end

    // Capture operands in READ and keep them frozen through HOLD; later
    // writebacks deliberately do not touch held operands.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_a   <= '0;
            op_b   <= '0;
            op_rd  <= '0;
            op_imm <= '0;
            op_ctl <= '0;
        end else if (load_ops) begin
            op_a   <= fwd_a ? wb_data : rf_dout1;
            op_b   <= fwd_b ? wb_data : rf_dout2;
            op_rd  <= rd_q;
            op_imm <= imm_q;
            op_ctl <= ctl_q;
        end
    end

    // Operand valid: raised by the capture, dropped once execute takes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_valid <= 1'b0;
        end else if (load_ops) begin
            op_valid <= 1'b1;
        end else if (release_ops) begin
            op_valid <= 1'b0;
        end
    end

endmodule : hs32_opfetch

// File: tb/tb_hs32_opfetch.sv
// Directed bench for hs32_opfetch paired with a 16x32 register file model
// whose read data is registered and frozen on write cycles.
module tb_hs32_opfetch;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;
    localparam int CTL_W  = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_rs1, req_rs2, req_rd;
    logic [DATA_W-1:0] req_imm;
    logic [CTL_W-1:0]  req_ctl;
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_adr;
    logic [DATA_W-1:0] wb_data;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_wadr, rf_radr1, rf_radr2;
    logic [DATA_W-1:0] rf_din, rf_dout1, rf_dout2;
    logic              op_valid;
    logic              op_ready;
    logic [DATA_W-1:0] op_a, op_b, op_imm;
    logic [ADDR_W-1:0] op_rd;
    logic [CTL_W-1:0]  op_ctl;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hs32_opfetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CTL_W(CTL_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_rs1  (req_rs1),
        .req_rs2  (req_rs2),
        .req_rd   (req_rd),
        .req_imm  (req_imm),
        .req_ctl  (req_ctl),
        .wb_valid (wb_valid),
        .wb_adr   (wb_adr),
        .wb_data  (wb_data),
        .rf_we    (rf_we),
        .rf_wadr  (rf_wadr),
        .rf_din   (rf_din),
        .rf_radr1 (rf_radr1),
        .rf_radr2 (rf_radr2),
        .rf_dout1 (rf_dout1),
        .rf_dout2 (rf_dout2),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .op_a     (op_a),
        .op_b     (op_b),
        .op_rd    (op_rd),
        .op_imm   (op_imm),
        .op_ctl   (op_ctl)
    );

    // Register file model: write has priority, reads are registered and
    // frozen on any edge that writes.
    logic [DATA_W-1:0] rf_mem [16];
    always @(posedge clk) begin
        if (rf_we) begin
            rf_mem[rf_wadr] <= rf_din;
        end else begin
            rf_dout1 <= rf_mem[rf_radr1];
            rf_dout2 <= rf_mem[rf_radr2];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled at negedge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_req(input logic v, input logic [3:0] rs1, input logic [3:0] rs2,
                           input logic [3:0] rd, input logic [31:0] imm, input logic [15:0] ctl);
        req_valid = v;
        req_rs1   = rs1;
        req_rs2   = rs2;
        req_rd    = rd;
        req_imm   = imm;
        req_ctl   = ctl;
    endtask

    task automatic set_wb(input logic v, input logic [3:0] adr, input logic [31:0] data);
        wb_valid = v;
        wb_adr   = adr;
        wb_data  = data;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        op_ready = 1'b0;
        set_req(1'b1, 4'd1, 4'd2, 4'd3, 32'h1, 16'h1);
        set_wb(1'b1, 4'd0, 32'h0);
        @(negedge clk);
        #1;
        check("rst_rf_we", rf_we, 0);
        check("rst_req_ready", req_ready, 0);
        tick();
        check("rst_op_valid", op_valid, 0);
        check("rst_op_a", op_a, 0);

        // Preload r3 and r4 through the writeback port.
        reset = 1'b0;
        set_req(1'b0, 4'd0, 4'd0, 4'd0, 32'h0, 16'h0);
        set_wb(1'b1, 4'd3, 32'h11111111);
        tick();
        set_wb(1'b1, 4'd4, 32'h22222222);
        tick();

        // Basic fetch: rs1=3, rs2=4.
        set_wb(1'b0, 4'd0, 32'h0);
        op_ready = 1'b1;
        set_req(1'b1, 4'd3, 4'd4, 4'd5, 32'h100, 16'hABCD);
        #1;
        check("t1_ready_idle", req_ready, 1);
        check("t1_radr1", rf_radr1, 3);
        tick();                                     // edge E -> READ
        set_req(1'b1, 4'd9, 4'd10, 4'd0, 32'h0, 16'h0);
        #1;
        check("t1_ready_read", req_ready, 0);
        check("t1_radr1_held", rf_radr1, 3);
        check("t1_valid_read", op_valid, 0);
        tick();                                     // edge E+1 -> HOLD
        set_req(1'b0, 4'd0, 4'd0, 4'd0, 32'h0, 16'h0);
        check("t1_valid", op_valid, 1);
        check("t1_op_a", op_a, 32'h11111111);
        check("t1_op_b", op_b, 32'h22222222);
        check("t1_op_rd", op_rd, 5);
        check("t1_op_imm", op_imm, 32'h100);
        check("t1_op_ctl", op_ctl, 16'hABCD);
        tick();                                     // consumed -> IDLE
        check("t1_valid_drop", op_valid, 0);

        // Forwarding during READ: r3 <- DEADBEEF.
        set_req(1'b1, 4'd3, 4'd4, 4'd5, 32'h100, 16'hABCD);
        tick();
        set_req(1'b0, 4'd0, 4'd0, 4'd0, 32'h0, 16'h0);
        set_wb(1'b1, 4'd3, 32'hDEADBEEF);
        tick();
        set_wb(1'b0, 4'd0, 32'h0);
        check("t2_op_a_fwd", op_a, 32'hDEADBEEF);
        check("t2_op_b", op_b, 32'h22222222);
        tick();

        // Writeback stall: three write cycles with a pending request.
        set_req(1'b1, 4'd3, 4'd4, 4'd6, 32'h200, 16'h0001);
        set_wb(1'b1, 4'd8, 32'h00000088);
        #1;
        check("t3_stall0", req_ready, 0);
        tick();
        set_wb(1'b1, 4'd9, 32'h00000099);
        #1;
        check("t3_stall1", req_ready, 0);
        tick();
        set_wb(1'b1, 4'd3, 32'h33333333);
        #1;
        check("t3_stall2", req_ready, 0);
        tick();
        set_wb(1'b0, 4'd0, 32'h0);
        #1;
        check("t3_accept", req_ready, 1);
        tick();                                     // -> READ
        set_req(1'b0, 4'd0, 4'd0, 4'd0, 32'h0, 16'h0);
        op_ready = 1'b0;
        check("t3_mem8", rf_mem[8], 32'h00000088);
        check("t3_mem9", rf_mem[9], 32'h00000099);
        check("t3_mem3", rf_mem[3], 32'h33333333);
        tick();                                     // -> HOLD
        check("t3_op_a", op_a, 32'h33333333);
        check("t3_op_b", op_b, 32'h22222222);

        // HOLD backpressure with r3 rewritten, then back-to-back accept.
        set_wb(1'b1, 4'd3, 32'hCAFEF00D);
        #1;
        check("t4_ready_wb", req_ready, 0);
        tick();
        set_wb(1'b0, 4'd0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            check("t4_hold_valid", op_valid, 1);
            check("t4_hold_op_a", op_a, 32'h33333333);
            tick();
        end
        op_ready = 1'b1;
        set_req(1'b1, 4'd3, 4'd8, 4'd7, 32'h300, 16'h0002);
        #1;
        check("t4_b2b_ready", req_ready, 1);
        check("t4_b2b_valid", op_valid, 1);
        tick();                                     // HOLD -> READ
        set_req(1'b0, 4'd0, 4'd0, 4'd0, 32'h0, 16'h0);
        check("t4_gap_valid", op_valid, 0);
        tick();
        check("t4_valid2", op_valid, 1);
        check("t4_op_a2", op_a, 32'hCAFEF00D);
        check("t4_op_b2", op_b, 32'h00000088);
        check("t4_op_rd2", op_rd, 7);
        tick();

        // Reset in READ discards the request.
        set_req(1'b1, 4'd4, 4'd4, 4'd2, 32'h55, 16'h1234);
        tick();                                     // -> READ
        reset = 1'b1;
        set_req(1'b0, 4'd0, 4'd0, 4'd0, 32'h0, 16'h0);
        set_wb(1'b1, 4'd10, 32'h0BADF00D);
        #1;
        check("t5_rst_we", rf_we, 0);
        check("t5_rst_ready", req_ready, 0);
        tick();
        check("t5_valid", op_valid, 0);
        check("t5_op_a", op_a, 0);
        check("t5_op_b", op_b, 0);
        check("t5_op_imm", op_imm, 0);
        check("t5_op_rd", op_rd, 0);
        check("t5_op_ctl", op_ctl, 0);
        check("t5_radr1", rf_radr1, 0);
        reset = 1'b0;
        set_wb(1'b0, 4'd0, 32'h0);
        #1;
        check("t5_idle_ready", req_ready, 1);
        tick();
        check("t5_no_valid", op_valid, 0);

        // rs1 == rs2 with forwarding.
        set_req(1'b1, 4'd7, 4'd7, 4'd1, 32'h7, 16'h0007);
        tick();
        set_req(1'b0, 4'd0, 4'd0, 4'd0, 32'h0, 16'h0);
        set_wb(1'b1, 4'd7, 32'hA5A5A5A5);
        tick();
        set_wb(1'b0, 4'd0, 32'h0);
        check("t6_valid", op_valid, 1);
        check("t6_op_a", op_a, 32'hA5A5A5A5);
        check("t6_op_b", op_b, 32'hA5A5A5A5);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_hs32_opfetch
